// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin
// encodings, coin values and the default price table.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE
  } vend_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;

  localparam int DEF_N_PROD   = 4;
  localparam int DEF_CREDIT_W = 6;

  // Entry i sits at bits [i*CREDIT_W +: CREDIT_W]; product 0 costs 15.
  localparam logic [DEF_N_PROD*DEF_CREDIT_W-1:0] DEF_PRICE_VEC =
    {6'd35, 6'd25, 6'd20, 6'd15};

  // Value of a coin encoding; the invalid code 2'b11 is worth nothing.
  function automatic int coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return VAL_5;
      COIN_10: return VAL_10;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_seq.sv
// Change-return sequencer: greedy ₹10/₹5 coin selection and the
// chg_req/chg_ack handshake, with a one-cycle low gap between coins.
module vend_change_seq
  import vend_pkg::*;
#(
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                chg_ack,
  output logic                chg_req,
  output logic [1:0]          chg_coin,
  output logic                done,
  output logic [CREDIT_W-1:0] dec
);

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_GAP,
    CS_REQ
  } phase_t;

  localparam logic [CREDIT_W-1:0] V10 = CREDIT_W'(VAL_10);

  phase_t     phase, phase_nx;
  logic       chg_req_nx;
  logic [1:0] chg_coin_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase    <= CS_IDLE;
      chg_req  <= 1'b0;
      chg_coin <= COIN_NONE;
    end else begin
      phase    <= phase_nx;
      chg_req  <= chg_req_nx;
      chg_coin <= chg_coin_nx;
    end
  end

  // NOTE: every variable is given a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_nx    = phase;
    chg_req_nx  = chg_req;
    chg_coin_nx = chg_coin;
    done        = 1'b0;
    dec         = '0;
    case (phase)
      CS_IDLE: begin
        if (start) phase_nx = CS_GAP;
      end
      CS_GAP: begin
        // Credit here already reflects the last ejected coin.
        if (credit == '0) begin
          done     = 1'b1;
          phase_nx = CS_IDLE;
        end else begin
          chg_req_nx  = 1'b1;
          chg_coin_nx = (credit >= V10) ? COIN_10 : COIN_5;
          phase_nx    = CS_REQ;
        end
      end
      CS_REQ: begin
        if (chg_ack) begin
          chg_req_nx  = 1'b0;
          chg_coin_nx = COIN_NONE;
          dec         = CREDIT_W'(coin_value(chg_coin));
          done        = (credit <= dec);
          phase_nx    = done ? CS_IDLE : CS_GAP;
        end
      end
      default: phase_nx = CS_IDLE;
    endcase
  end

endmodule

// File: rtl/vend_controller.sv
// Multi-product vending controller: credit accumulation, price check,
// dispenser handshake and coin-by-coin change return.
// Define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYC idle cycles.
module vend_controller
  import vend_pkg::*;
#(
  parameter int N_PROD      = DEF_N_PROD,
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter int MAX_CREDIT  = 50,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICE_VEC = DEF_PRICE_VEC,
  parameter int TIMEOUT_CYC = 1000,
  localparam int SEL_W      = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          money,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                disp_req,
  output logic [SEL_W-1:0]    disp_id,
  input  logic                disp_ack,
  output logic                chg_req,
  output logic [1:0]          chg_coin,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                err_insufficient
);

  if (MAX_CREDIT > (2**CREDIT_W) - 1 || (MAX_CREDIT % 5) != 0) begin : g_bad_max_credit
    $error("vend_controller: MAX_CREDIT must fit CREDIT_W and be a multiple of 5");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("vend_controller: TIMEOUT_CYC must be at least 1");
  end

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] id);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (id == SEL_W'(i)) p = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  vend_state_t         state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic                disp_req_nx;
  logic [SEL_W-1:0]    disp_id_nx;
  logic                coin_reject_nx;
  logic                err_nx;
  logic                chg_start;
  logic                chg_done;
  logic [CREDIT_W-1:0] chg_dec;

  logic                coin_valid;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;

  assign coin_valid = (money == COIN_5) || (money == COIN_10);
  assign coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_value(money));
  assign coin_fits  = (coin_sum <= MAX_SUM);
  assign sel_price  = price_of(sel_id);
  // An out-of-range id has no price and is reported as insufficient.
  assign sel_ok     = (int'(sel_id) < N_PROD) && (credit >= sel_price);

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;
`endif

  vend_change_seq #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (chg_start),
    .credit   (credit),
    .chg_ack  (chg_ack),
    .chg_req  (chg_req),
    .chg_coin (chg_coin),
    .done     (chg_done),
    .dec      (chg_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      credit           <= '0;
      disp_req         <= 1'b0;
      disp_id          <= '0;
      busy             <= 1'b0;
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      state            <= state_nx;
      credit           <= credit_nx;
      disp_req         <= disp_req_nx;
      disp_id          <= disp_id_nx;
      busy             <= (state_nx == ST_DISPENSE) || (state_nx == ST_CHANGE);
      coin_reject      <= coin_reject_nx;
      err_insufficient <= err_nx;
`ifdef VEND_TIMEOUT_EN
      tmo_cnt          <= tmo_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx       = state;
    credit_nx      = credit;
    disp_req_nx    = disp_req;
    disp_id_nx     = disp_id;
    coin_reject_nx = 1'b0;
    err_nx         = 1'b0;
    chg_start      = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_cnt_nx     = '0;
`endif
    case (state)
      ST_IDLE: begin
        if (sel_valid) err_nx = 1'b1;
        if (coin_valid) begin
          if (coin_fits) begin
            credit_nx = coin_sum[CREDIT_W-1:0];
            state_nx  = ST_CREDIT;
          end else begin
            coin_reject_nx = 1'b1;
          end
        end
      end
      ST_CREDIT: begin
        // cancel beats select beats coin; a losing coin is bounced.
        if (cancel) begin
          coin_reject_nx = coin_valid;
          chg_start      = 1'b1;
          state_nx       = ST_CHANGE;
        end else if (sel_valid) begin
          coin_reject_nx = coin_valid;
          if (sel_ok) begin
            credit_nx   = credit - sel_price;
            disp_req_nx = 1'b1;
            disp_id_nx  = sel_id;
            state_nx    = ST_DISPENSE;
          end else begin
            err_nx = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) credit_nx = coin_sum[CREDIT_W-1:0];
          else           coin_reject_nx = 1'b1;
        end
`ifdef VEND_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          chg_start = 1'b1;
          state_nx  = ST_CHANGE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
        end
`endif
      end
      ST_DISPENSE: begin
        coin_reject_nx = coin_valid;
        if (disp_ack) begin
          disp_req_nx = 1'b0;
          if (credit != '0) begin
            chg_start = 1'b1;
            state_nx  = ST_CHANGE;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        coin_reject_nx = coin_valid;
        credit_nx      = credit - chg_dec;
        if (chg_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed vector table, multi-cycle
// corner sequences and randomized stimulus against a behavioural model.
module tb_vend_controller;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] money;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       disp_ack;
  logic       chg_req;
  logic [1:0] chg_coin;
  logic       chg_ack;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       err_insufficient;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_controller #(
    .N_PROD      (4),
    .CREDIT_W    (6),
    .MAX_CREDIT  (50),
    .PRICE_VEC   ({6'd35, 6'd25, 6'd20, 6'd15}),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .money            (money),
    .sel_valid        (sel_valid),
    .sel_id           (sel_id),
    .cancel           (cancel),
    .disp_req         (disp_req),
    .disp_id          (disp_id),
    .disp_ack         (disp_ack),
    .chg_req          (chg_req),
    .chg_coin         (chg_coin),
    .chg_ack          (chg_ack),
    .credit           (credit),
    .busy             (busy),
    .coin_reject      (coin_reject),
    .err_insufficient (err_insufficient)
  );

  typedef struct {
    logic [1:0] m;
    logic       sv;
    logic [1:0] sid;
    logic       can;
    logic       dack;
    logic       cack;
    logic       e_dreq;
    logic [1:0] e_did;
    logic       e_creq;
    logic [1:0] e_coin;
    int         e_cred;
    logic       e_busy;
    logic       e_rej;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] m, input logic sv, input logic [1:0] sid,
                              input logic can, input logic dack, input logic cack,
                              input logic dreq, input logic [1:0] did, input logic creq,
                              input logic [1:0] coin, input int cred, input logic bsy,
                              input logic rej, input logic err);
    vec_t v;
    v.m = m; v.sv = sv; v.sid = sid; v.can = can; v.dack = dack; v.cack = cack;
    v.e_dreq = dreq; v.e_did = did; v.e_creq = creq; v.e_coin = coin;
    v.e_cred = cred; v.e_busy = bsy; v.e_rej = rej; v.e_err = err;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic sv, input logic [1:0] sid,
                       input logic can, input logic dack, input logic cack);
    money = m; sel_valid = sv; sel_id = sid; cancel = can; disp_ack = dack; chg_ack = cack;
  endtask

  task automatic idle_in();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] out_vec();
    return {17'b0, disp_req, disp_id, chg_req, chg_coin, credit, busy, coin_reject,
            err_insufficient};
  endfunction

  // Behavioural model: credit as an integer, change as a queue of coin values
  // worked out up front when the refund starts.
  int price[4] = '{15, 20, 25, 35};
  int m_credit;
  int m_mode;      // 0 taking coins, 1 vending, 2 refunding
  int m_did;
  int m_q[$];
  bit m_req_up;
  bit m_rej;
  bit m_err;

  function automatic void model_reset();
    m_credit = 0; m_mode = 0; m_did = 0; m_q.delete(); m_req_up = 0; m_rej = 0; m_err = 0;
  endfunction

  function automatic void start_refund();
    int c;
    c = m_credit;
    m_q.delete();
    while (c >= 10) begin m_q.push_back(10); c -= 10; end
    if (c > 0) m_q.push_back(c);
    m_req_up = 0;
    m_mode = 2;
  endfunction

  function automatic void model_step(input logic [1:0] m, input logic sv, input logic [1:0] sid,
                                     input logic can, input logic dack, input logic cack);
    int coin;
    coin = (m == 2'd1) ? 5 : (m == 2'd2) ? 10 : 0;
    m_rej = 0;
    m_err = 0;
    if (m_mode == 0) begin
      if (m_credit > 0 && can) begin
        m_rej = (coin > 0);
        start_refund();
      end else if (sv) begin
        if (m_credit == 0) m_err = 1;
        else begin
          m_rej = (coin > 0);
          if (price[sid] <= m_credit) begin
            m_credit -= price[sid];
            m_did = int'(sid);
            m_mode = 1;
          end else m_err = 1;
        end
      end else if (coin > 0) begin
        if (m_credit + coin <= 50) m_credit += coin;
        else m_rej = 1;
      end
    end else if (m_mode == 1) begin
      m_rej = (coin > 0);
      if (dack) begin
        if (m_credit > 0) start_refund();
        else m_mode = 0;
      end
    end else begin
      m_rej = (coin > 0);
      if (m_req_up) begin
        if (cack) begin
          m_credit -= m_q[0];
          void'(m_q.pop_front());
          m_req_up = 0;
          if (m_q.size() == 0) m_mode = 0;
        end
      end else m_req_up = 1;
    end
  endfunction

  function automatic logic [31:0] model_vec();
    logic [1:0] coin;
    coin = !m_req_up ? 2'd0 : (m_q[0] == 10) ? 2'd2 : 2'd1;
    return {17'b0, (m_mode == 1), 2'(m_did), m_req_up, coin, 6'(m_credit), (m_mode != 0),
            m_rej, m_err};
  endfunction

  initial begin
    reset_n = 1'b0;
    idle_in();
    tick();
    tick();
    check("reset.outputs", out_vec(), 32'd0);
    reset_n = 1'b1;

    // m sv sid can dack cack | dreq did creq coin cred busy rej err
    add(2,0,0,0,0,0, 0,0,0,0,10,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,15,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0);   // exact-price select
    add(0,0,0,0,0,0, 1,0,0,0, 0,1,0,0);
    add(0,0,0,0,1,0, 0,0,0,0, 0,0,0,0);   // no change owed
    add(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    add(2,0,0,0,0,0, 0,0,0,0,10,0,0,0);
    add(2,0,0,0,0,0, 0,0,0,0,20,0,0,0);
    add(2,0,0,0,0,0, 0,0,0,0,30,0,0,0);
    add(0,1,1,0,0,0, 1,1,0,0,10,1,0,0);
    add(0,0,0,0,1,0, 0,1,0,0,10,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,2,10,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,2,10,1,0,0);
    add(0,0,0,0,0,1, 0,1,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 0,1,0,0, 0,0,0,0);
    add(1,0,0,0,0,0, 0,1,0,0, 5,0,0,0);
    add(1,0,0,0,0,0, 0,1,0,0,10,0,0,0);
    add(0,1,2,0,0,0, 0,1,0,0,10,0,0,1);   // insufficient
    add(0,0,0,0,0,0, 0,1,0,0,10,0,0,0);
    add(0,0,0,1,0,0, 0,1,0,0,10,1,0,0);   // cancel refund
    add(0,0,0,0,0,0, 0,1,1,2,10,1,0,0);
    add(0,0,0,0,0,1, 0,1,0,0, 0,0,0,0);
    add(2,0,0,0,0,0, 0,1,0,0,10,0,0,0);
    add(2,0,0,0,0,0, 0,1,0,0,20,0,0,0);
    add(2,0,0,0,0,0, 0,1,0,0,30,0,0,0);
    add(2,0,0,0,0,0, 0,1,0,0,40,0,0,0);
    add(2,0,0,0,0,0, 0,1,0,0,50,0,0,0);
    add(2,0,0,0,0,0, 0,1,0,0,50,0,1,0);   // over ceiling
    add(0,0,0,0,0,0, 0,1,0,0,50,0,0,0);
    add(1,1,3,0,0,0, 1,3,0,0,15,1,1,0);   // coin loses to select
    add(1,0,0,0,1,0, 0,3,0,0,15,1,1,0);   // coin during dispense
    add(0,0,0,0,0,0, 0,3,1,2,15,1,0,0);
    add(0,0,0,0,0,1, 0,3,0,0, 5,1,0,0);
    add(0,0,0,0,0,0, 0,3,1,1, 5,1,0,0);   // gap then ₹5 coin
    add(0,0,0,0,0,1, 0,3,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 0,3,0,0, 0,0,0,1);   // select in idle
    add(3,0,0,0,0,0, 0,3,0,0, 0,0,0,0);   // invalid coin ignored
    add(0,0,0,0,1,1, 0,3,0,0, 0,0,0,0);   // stray acks ignored
    add(0,0,0,1,0,0, 0,3,0,0, 0,0,0,0);   // cancel in idle ignored
    add(1,0,0,0,0,0, 0,3,0,0, 5,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].m, vecs[i].sv, vecs[i].sid, vecs[i].can, vecs[i].dack, vecs[i].cack);
      tick();
      check($sformatf("v%0d.disp_req", i), 32'(disp_req), 32'(vecs[i].e_dreq));
      check($sformatf("v%0d.disp_id", i), 32'(disp_id), 32'(vecs[i].e_did));
      check($sformatf("v%0d.chg_req", i), 32'(chg_req), 32'(vecs[i].e_creq));
      check($sformatf("v%0d.chg_coin", i), 32'(chg_coin), 32'(vecs[i].e_coin));
      check($sformatf("v%0d.credit", i), 32'(credit), 32'(vecs[i].e_cred));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d.coin_reject", i), 32'(coin_reject), 32'(vecs[i].e_rej));
      check($sformatf("v%0d.err_insufficient", i), 32'(err_insufficient), 32'(vecs[i].e_err));
    end

    // Reset while a change coin is being requested.
    do_reset();
    drive(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
    idle_in(); tick();
    check("rst.pre_chg_req", 32'(chg_req), 32'd1);
    reset_n = 1'b0;
    tick();
    check("rst.outputs", out_vec(), 32'd0);
    reset_n = 1'b1;
    drive(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    check("rst.credit_restart", 32'(credit), 32'd5);
    check("rst.busy", 32'(busy), 32'd0);

`ifdef VEND_TIMEOUT_EN
    do_reset();
    drive(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    idle_in();
    repeat (TMO - 1) tick();
    check("tmo.not_yet_busy", 32'(busy), 32'd0);
    check("tmo.credit_held", 32'(credit), 32'd15);
    tick();
    check("tmo.busy", 32'(busy), 32'd1);
    check("tmo.no_req_yet", 32'(chg_req), 32'd0);
    tick();
    check("tmo.req10", {30'd0, chg_req, chg_coin == 2'd2}, 32'd3);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    check("tmo.credit5", 32'(credit), 32'd5);
    tick();
    check("tmo.req5", {30'd0, chg_req, chg_coin == 2'd1}, 32'd3);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    check("tmo.credit0", 32'(credit), 32'd0);
    check("tmo.idle", 32'(busy), 32'd0);
`else
    do_reset();
    drive(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
    idle_in();
    repeat (TMO + 200) tick();
    check("notmo.credit", 32'(credit), 32'd15);
    check("notmo.busy", 32'(busy), 32'd0);
    check("notmo.chg_req", 32'(chg_req), 32'd0);
`endif

    // Randomized traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000 && bad < 20; c++) begin
      logic [1:0] m;
      logic       sv, can, dack, cack;
      logic [1:0] sid;
      int r;
      r    = $urandom_range(0, 9);
      m    = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      sv   = ($urandom_range(0, 7) == 0);
      sid  = 2'($urandom_range(0, 3));
      can  = ($urandom_range(0, 19) == 0);
      dack = ($urandom_range(0, 2) == 0);
      cack = ($urandom_range(0, 2) == 0);
      if (m_mode == 0 && m_credit == 0 && sv) m = 2'd0;
      drive(m, sv, sid, can, dack, cack);
      model_step(m, sv, sid, can, dack, cack);
      tick();
      check($sformatf("rand%0d", c), out_vec(), model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
